mem_port_arbiter: RTL

//  Shares one single-port unified memory between the pipeline's fetch port (IF)
//  and its load/store port (MEM). Only one transaction is outstanding at a time.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (IF) and load/store (D) ports; one transaction in flight.
// Optional performance counters are compiled in when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_if_gnts,
    output logic [31:0]         perf_d_gnts,
    output logic [31:0]         perf_conflicts
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;   // 1: data port owns the outstanding transaction
    logic [SW-1:0] starve_q, starve_d;

    logic idle;
    logic waiting;
    logic conflict;
    logic d_win;
    logic if_win;
    logic rsp;

    always_comb begin
        idle     = reset && (state_q == S_IDLE);
        waiting  = reset && (state_q == S_WAIT);
        conflict = if_req && d_req;
        // Data wins by default; fetch takes over once it has lost STARVE_MAX conflicts in a row.
        d_win    = d_req && !(if_req && (starve_q == STARVE_LIM));
        if_win   = if_req && !d_win;

        if_gnt    = idle && if_win;
        d_gnt     = idle && d_win;
        mem_req   = if_gnt || d_gnt;
        mem_we    = d_win && d_we;
        mem_addr  = d_win ? d_addr : if_addr;
        mem_wdata = d_win ? d_wdata : '0;
        mem_wstrb = d_win ? d_wstrb : '0;

        rsp       = waiting && mem_rvalid;
        if_rvalid = rsp && !owner_q;
        d_rvalid  = rsp && owner_q;
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
        busy      = waiting;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        if (mem_req) begin
            state_d = S_WAIT;
            owner_d = d_gnt;
        end else if (rsp) begin
            state_d = S_IDLE;
        end
        if (if_gnt) begin
            starve_d = '0;
        end else if (d_gnt && conflict && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_cf_q, perf_cf_d;

    always_comb begin
        perf_if_d = perf_if_q + (if_gnt ? 32'd1 : 32'd0);
        perf_d_d  = perf_d_q + (d_gnt ? 32'd1 : 32'd0);
        perf_cf_d = perf_cf_q + ((idle && conflict) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_if_q <= '0;
            perf_d_q  <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_d_q  <= perf_d_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_if_gnts   = perf_if_q;
    assign perf_d_gnts    = perf_d_q;
    assign perf_conflicts = perf_cf_q;
`endif

endmodule
